// File: rtl/machine_timer_intc.sv
// machine_timer_intc
//   Machine-level interrupt source for the trap unit: 64-bit mtime with a
//   prescaled tick, 64-bit mtimecmp, software interrupt bit (msip), enable
//   mask (ie = {meie, mtie, msie}) and a synchronised external line. All
//   three sources fold into one registered level intr plus a cause code.
// Ports
//   clk, rst            core clock, synchronous active-high reset
//   bus_req/we/addr/wdat single-beat load/store access
//   bus_rdy/bus_rdat     completion one cycle after bus_req, registered data
//   ext_irq              asynchronous external interrupt level
//   intr/intr_cause      level request and cause (11 ext, 3 sw, 7 timer, 0)
module machine_timer_intc #(
   parameter int unsigned PRESCALE  = 16,
   parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bus_req,
   input  logic        bus_we,
   input  logic [31:0] bus_addr,
   input  logic [31:0] bus_wdat,
   output logic        bus_rdy,
   output logic [31:0] bus_rdat,
   input  logic        ext_irq,
   output logic        intr,
   output logic [3:0]  intr_cause
);

   localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

   logic [63:0] mtime;
   logic [63:0] mtimecmp;
   logic        msip;
   logic [2:0]  ie;
   logic [15:0] presc;
   logic [1:0]  sync;
   logic        tpend;

   logic [2:0]  idx;
   logic        hit;
   logic        wr;
   logic        wr_mtime;
   logic        tick;
   logic [31:0] rd_mux;
   logic        intr_nxt;
   logic [3:0]  cause_nxt;
   logic        epend;

   // byte-lane bits are don't-care for word registers
   logic unused_addr;
   assign unused_addr = &{1'b0, bus_addr[1:0]};

   assign idx      = bus_addr[4:2];
   assign hit      = bus_req && (bus_addr[31:5] == BASE_ADDR[31:5]) && (idx <= 3'd5);
   assign wr       = hit && bus_we;
   assign wr_mtime = wr && (idx == 3'd0 || idx == 3'd1);
   assign tick     = (presc == PS_LAST);
   assign epend    = sync[1];

   // read mux sees register values before this cycle's write/tick
   always_comb begin
      rd_mux = '0;
      case (idx)
         3'd0: rd_mux = mtime[31:0];
         3'd1: rd_mux = mtime[63:32];
         3'd2: rd_mux = mtimecmp[31:0];
         3'd3: rd_mux = mtimecmp[63:32];
         3'd4: rd_mux = {31'd0, msip};
         3'd5: rd_mux = {29'd0, ie};
         default: rd_mux = '0;
      endcase
   end

   always_comb begin
      intr_nxt  = (epend & ie[2]) | (msip & ie[0]) | (tpend & ie[1]);
      cause_nxt = 4'd0;
      if (epend & ie[2])      cause_nxt = 4'd11;
      else if (msip & ie[0])  cause_nxt = 4'd3;
      else if (tpend & ie[1]) cause_nxt = 4'd7;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mtime      <= '0;
         mtimecmp   <= '1;
         msip       <= 1'b0;
         ie         <= 3'b000;
         presc      <= '0;
         sync       <= 2'b00;
         tpend      <= 1'b0;
         bus_rdy    <= 1'b0;
         bus_rdat   <= '0;
         intr       <= 1'b0;
         intr_cause <= 4'd0;
      end else begin
         bus_rdy  <= bus_req;
         bus_rdat <= (hit && !bus_we) ? rd_mux : '0;

         // a software write to mtime wins over the tick and restarts the prescaler
         if (wr_mtime) begin
            presc <= '0;
            if (idx == 3'd0) mtime[31:0]  <= bus_wdat;
            else             mtime[63:32] <= bus_wdat;
         end else if (tick) begin
            presc <= '0;
            mtime <= mtime + 64'd1;
         end else begin
            presc <= presc + 16'd1;
         end

         if (wr && idx == 3'd2) mtimecmp[31:0]  <= bus_wdat;
         if (wr && idx == 3'd3) mtimecmp[63:32] <= bus_wdat;
         if (wr && idx == 3'd4) msip            <= bus_wdat[0];
         if (wr && idx == 3'd5) ie              <= bus_wdat[2:0];

         sync <= {sync[0], ext_irq};

         // compares the registered values, so it trails the crossing by a cycle
         tpend <= (mtime >= mtimecmp);

         intr       <= intr_nxt;
         intr_cause <= cause_nxt;
      end
   end

endmodule

// File: tb/tb_machine_timer_intc.sv
module tb_machine_timer_intc;

   localparam logic [31:0] BASE = 32'h0200_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        bus_req = 1'b0;
   logic        bus_we = 1'b0;
   logic [31:0] bus_addr = '0;
   logic [31:0] bus_wdat = '0;
   logic        ext_irq = 1'b0;
   logic        sel = 1'b0;   // 0: PRESCALE=4 instance, 1: PRESCALE=1 instance

   logic        req4, req1, rdy4, rdy1, intr4, intr1;
   logic [31:0] rdat4, rdat1;
   logic [3:0]  cause4, cause1;

   int total = 0;
   int bad = 0;

   assign req4 = bus_req & ~sel;
   assign req1 = bus_req & sel;

   always #5 clk = ~clk;

   machine_timer_intc #(.PRESCALE(4), .BASE_ADDR(BASE)) u_p4 (
      .clk(clk), .rst(rst), .bus_req(req4), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdat(bus_wdat), .bus_rdy(rdy4), .bus_rdat(rdat4), .ext_irq(ext_irq),
      .intr(intr4), .intr_cause(cause4));

   machine_timer_intc #(.PRESCALE(1), .BASE_ADDR(BASE)) u_p1 (
      .clk(clk), .rst(rst), .bus_req(req1), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdat(bus_wdat), .bus_rdy(rdy1), .bus_rdat(rdat1), .ext_irq(ext_irq),
      .intr(intr1), .intr_cause(cause1));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // called just after a negedge; the access is sampled on the next posedge
   task automatic acc(input logic we, input logic [31:0] addr, input logic [31:0] wdat,
                      output logic [31:0] rd);
      bus_req = 1'b1; bus_we = we; bus_addr = addr; bus_wdat = wdat;
      @(negedge clk);
      bus_req = 1'b0; bus_we = 1'b0;
      chk("rdy", sel ? rdy1 : rdy4, 1'b1);
      rd = sel ? rdat1 : rdat4;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] d);
      logic [31:0] rd;
      acc(1'b1, addr, d, rd);
      chk("wr_rdat", rd, 32'd0);
   endtask

   task automatic rdc(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      logic [31:0] rd;
      acc(1'b0, addr, 32'd0, rd);
      chk(tag, rd, exp);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   logic [31:0] exp_rst [6] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};

   initial begin
      @(negedge clk);
      // ---- 1: reset values and one-cycle rdy ----
      sel = 1'b0;
      do_reset();
      chk("rst_intr", intr4, 1'b0);
      chk("rst_cause", cause4, 4'd0);
      chk("rst_rdy", rdy4, 1'b0);
      chk("rst_rdat", rdat4, 32'd0);
      for (int i = 0; i < 6; i++) begin
         rdc($sformatf("rst_reg%0d", i), BASE + 32'(i * 4), exp_rst[i]);
         @(negedge clk);
         chk("rdy_drop", rdy4, 1'b0);
         chk("rdat_idle", rdat4, 32'd0);
      end

      // ---- 2: PRESCALE=4 tick rate and 32-bit carry ----
      do_reset();
      wait_cyc(40);
      rdc("mt_40", BASE + 32'h00, 32'd10);
      wr(BASE + 32'h00, 32'hFFFF_FFFF);
      wr(BASE + 32'h04, 32'h0);
      wait_cyc(3);
      rdc("mt_lo_pre", BASE + 32'h00, 32'hFFFF_FFFF);
      rdc("mt_hi_carry", BASE + 32'h04, 32'd1);
      rdc("mt_lo_wrap", BASE + 32'h00, 32'd0);

      // ---- 3: timer interrupt timing, PRESCALE=1 ----
      sel = 1'b1;
      do_reset();
      wr(BASE + 32'h14, 32'd2);
      wr(BASE + 32'h08, 32'd20);
      wr(BASE + 32'h00, 32'd0);      // mtime=0 at edge E0
      wr(BASE + 32'h0C, 32'd0);      // mtimecmp = 20
      wait_cyc(20);                  // now just after E21
      chk("t_pre", intr1, 1'b0);
      wait_cyc(1);                   // just after E22
      chk("t_rise", intr1, 1'b1);
      chk("t_cause", cause1, 4'd7);
      wr(BASE + 32'h08, 32'd1000);
      chk("t_hold0", intr1, 1'b1);
      wait_cyc(1);
      chk("t_hold1", intr1, 1'b1);
      wait_cyc(1);
      chk("t_fall", intr1, 1'b0);
      chk("t_fall_cause", cause1, 4'd0);

      // ---- 4: priority sw > timer, ext on top, no gap on ext drop ----
      wr(BASE + 32'h14, 32'd7);
      wr(BASE + 32'h10, 32'd1);
      wr(BASE + 32'h08, 32'd0);
      wait_cyc(2);
      chk("p_intr", intr1, 1'b1);
      chk("p_sw", cause1, 4'd3);
      ext_irq = 1'b1;
      wait_cyc(2);
      chk("p_ext_lat", cause1, 4'd3);
      wait_cyc(1);
      chk("p_ext", cause1, 4'd11);
      ext_irq = 1'b0;
      for (int i = 0; i < 3; i++) begin
         wait_cyc(1);
         chk("p_nogap", intr1, 1'b1);
      end
      chk("p_back_sw", cause1, 4'd3);

      // ---- 5: masking ----
      ext_irq = 1'b1;
      wait_cyc(3);
      wr(BASE + 32'h14, 32'd0);
      wait_cyc(1);
      chk("m_off", intr1, 1'b0);
      chk("m_off_cause", cause1, 4'd0);
      wr(BASE + 32'h14, 32'd1);
      chk("m_pre", intr1, 1'b0);
      wait_cyc(1);
      chk("m_on", intr1, 1'b1);
      chk("m_on_cause", cause1, 4'd3);

      // ---- 6: unmapped / miss accesses, reset during a read ----
      ext_irq = 1'b0;
      wr(BASE + 32'h18, 32'hFFFF_FFFF);
      wr(32'h0300_0010, 32'h0);
      wr(32'h0300_0014, 32'h7);
      rdc("u_18", BASE + 32'h18, 32'd0);
      rdc("u_miss", 32'h0300_0010, 32'd0);
      rdc("u_msip", BASE + 32'h10, 32'd1);
      rdc("u_ie", BASE + 32'h14, 32'd1);
      rdc("u_cmp_lo", BASE + 32'h08, 32'd0);
      bus_req = 1'b1; bus_we = 1'b0; bus_addr = BASE + 32'h10; rst = 1'b1;
      @(negedge clk);
      bus_req = 1'b0; rst = 1'b0;
      chk("r_rdy", rdy1, 1'b0);
      chk("r_rdat", rdat1, 32'd0);
      rdc("r_msip", BASE + 32'h10, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
